inst_sequencer: RTL and testbench

- Instruction-side responder for the single-cycle SP core; sits opposite the core on the inst / in_valid / out_valid / inst_addr handshake.
- Holds a loadable program buffer and issues one instruction at a time.
- After issuing, waits for the core's out_valid and inst_addr, then fetches the next word from inst_addr.
- Flags program completion, protocol violations and hangs. Used as a synthesizable stimulus engine in place of a behavioural pattern.

---
 rtl/inst_seq_pkg.sv | 23 ++
 rtl/inst_sequencer_if.sv | 27 ++
 rtl/inst_buf.sv | 30 +++
 rtl/inst_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_inst_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_seq_pkg.sv
// Shared types and constants for the instruction sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package inst_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ADDR    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_SPUR    = 2'd3;

    // Byte address -> word index shift (32-bit instruction words).
    localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/inst_sequencer_if.sv
// Instruction handshake between the sequencer and the core.
// Latency: n/a (wires only).
// Backpressure: none; the core answers each in_valid pulse with one out_valid.
//   master (sequencer): drives in_valid/inst, receives out_valid/inst_addr.
//   slave  (core)     : receives in_valid/inst, drives out_valid/inst_addr.
interface inst_sequencer_if;

    logic        in_valid;
    logic [31:0] inst;
    logic        out_valid;
    logic [31:0] inst_addr;

    modport master (
        output in_valid,
        output inst,
        input  out_valid,
        input  inst_addr
    );

    modport slave (
        input  in_valid,
        input  inst,
        output out_valid,
        output inst_addr
    );

endinterface

// File: rtl/inst_buf.sv
// Program buffer: 2**AW x 32, one write port, one read port.
// Latency: read data valid the cycle after rd_en.
// Backpressure: none; read-before-write when both ports hit the same word.
//   wr_en/wr_addr/wr_data : synchronous write port
//   rd_en/rd_addr/rd_data : synchronous read port, rd_data holds when rd_en=0
module inst_buf #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [0:(1<<AW)-1];

    // Contents deliberately survive reset so a program can be rerun.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/inst_sequencer.sv
// Instruction-side responder: issues buffered program words to the core one at a time.
// Latency: in_valid 2 cycles after start or after the core's out_valid (FETCH, ISSUE).
// Backpressure: waits up to TIMEOUT cycles for out_valid; flags address/timeout/spurious errors.
//   clk/rst                   : clock, synchronous active-high reset
//   load_en/load_addr/load_data : program load, accepted in IDLE/DONE/ERR
//   start/prog_len            : run from word 0 over prog_len words
//   core                      : instruction handshake to the core
//   done/error/err_code/issued_cnt : status
module inst_sequencer
    import inst_seq_pkg::*;
#(
    parameter int AW      = 8,
    parameter int TIMEOUT = 1024,
    parameter int CW      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [31:0]      load_data,
    input  logic             start,
    input  logic [AW:0]      prog_len,
    inst_sequencer_if.master core,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [CW-1:0]    issued_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] timer_q;
    logic [AW-1:0] pc_q;
    logic [AW:0]   len_q;
    logic [31:0]   inst_q;
    logic [31:0]   rd_data;

    logic          idle_like;
    logic          buf_wr;
    logic          rd_en;
    logic          addr_bad;
    logic          past_end;
    logic [AW-1:0] resp_word;

    logic          do_start;
    logic          set_done;
    logic          set_err;
    logic [1:0]    err_d;
    logic          load_pc;
    logic          issue;

    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
    assign buf_wr    = load_en && idle_like;

    // Response decode: must be word aligned and fit inside the buffer.
    assign resp_word = core.inst_addr[AW+WORD_SHIFT-1:WORD_SHIFT];
    assign addr_bad  = (core.inst_addr[WORD_SHIFT-1:0] != '0)
                    || ((core.inst_addr >> (AW + WORD_SHIFT)) != 32'd0);
    assign past_end  = {1'b0, resp_word} >= len_q;

    inst_buf #(.AW(AW)) u_buf (
        .clk     (clk),
        .wr_en   (buf_wr),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_en   (rd_en),
        .rd_addr (pc_q),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        do_start = 1'b0;
        set_done = 1'b0;
        set_err  = 1'b0;
        err_d    = ERR_NONE;
        load_pc  = 1'b0;
        rd_en    = 1'b0;
        issue    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                // start outranks a simultaneous stray out_valid; ERR ignores out_valid
                // so the first recorded error is never overwritten.
                if (start) begin
                    do_start = 1'b1;
                    if (prog_len == '0) begin
                        state_d  = S_DONE;
                        set_done = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else if (core.out_valid && (state_q != S_ERR)) begin
                    state_d = S_ERR;
                    set_err = 1'b1;
                    err_d   = ERR_SPUR;
                end
            end
            S_FETCH: begin
                rd_en = 1'b1;
                if (core.out_valid) begin
                    state_d = S_ERR;
                    set_err = 1'b1;
                    err_d   = ERR_SPUR;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                issue = 1'b1;
                // A response in the issue cycle itself is a protocol violation.
                if (core.out_valid) begin
                    state_d = S_ERR;
                    set_err = 1'b1;
                    err_d   = ERR_SPUR;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response on the last allowed cycle wins over the timeout.
                if (core.out_valid) begin
                    if (addr_bad) begin
                        state_d = S_ERR;
                        set_err = 1'b1;
                        err_d   = ERR_ADDR;
                    end else if (past_end) begin
                        state_d  = S_DONE;
                        set_done = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                        load_pc = 1'b1;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                    set_err = 1'b1;
                    err_d   = ERR_TIMEOUT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q    <= '0;
            pc_q       <= '0;
            len_q      <= '0;
            inst_q     <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
            issued_cnt <= '0;
        end else begin
            if (do_start) begin
                len_q      <= prog_len;
                pc_q       <= '0;
                done       <= 1'b0;
                error      <= 1'b0;
                err_code   <= ERR_NONE;
                issued_cnt <= '0;
            end
            if (set_done) begin
                done <= 1'b1;
            end
            if (set_err) begin
                error    <= 1'b1;
                err_code <= err_d;
            end
            if (load_pc) begin
                pc_q <= resp_word;
            end
            if (issue) begin
                inst_q  <= rd_data;
                timer_q <= '0;
                if (issued_cnt != '1) begin
                    issued_cnt <= issued_cnt + 1'b1;
                end
            end else if (state_q == S_WAIT) begin
                timer_q <= timer_q + 1'b1;
            end
        end
    end

    // inst shows fresh read data during the issue cycle and holds it afterwards.
    assign core.in_valid = (state_q == S_ISSUE);
    assign core.inst     = (state_q == S_ISSUE) ? rd_data : inst_q;

endmodule

// File: tb/tb_inst_sequencer.sv
module tb_inst_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [31:0] load_data;
    logic        start;
    logic [4:0]  prog_len;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [3:0]  issued_cnt;

    inst_sequencer_if bus();

    inst_sequencer #(.AW(4), .TIMEOUT(16), .CW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .start      (start),
        .prog_len   (prog_len),
        .core       (bus),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .issued_cnt (issued_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [16];
    logic [31:0] plan [$];

    typedef struct {
        logic [31:0] addr;
        int          len;
        bit          vld;
        logic [31:0] inst;
        bit          dn;
        bit          er;
        logic [1:0]  code;
    } vec_t;
    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int n);
        return (n > 15) ? 15 : n;
    endfunction

    task automatic load_word(input int addr, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = 4'(addr);
        load_data = d;
        ref_mem[addr] = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 64'({bus.in_valid, bus.inst, done, error, err_code, issued_cnt}), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.out_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_out");
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Core model + reference: issue order follows the response addresses, each
    // issue lands 2 cycles after the response, termination from the address rules.
    task automatic run_core(input int len, input bit rnd);
        int          k, exp_issue, resp_cyc, pc, issues, pulses, kind, r;
        logic [31:0] a;
        bit          fin;
        k = 0; resp_cyc = -1; pc = 0; issues = 0; pulses = 0;
        exp_issue = (len == 0) ? -1 : 2;
        fin  = (len == 0);
        kind = (len == 0) ? 1 : 0;
        start = 1'b1;
        prog_len = 5'(len);
        while (!fin && k < 3000) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            bus.out_valid = 1'b0;
            if (rnd) begin
                load_en   = 1'($urandom_range(0, 1));
                load_addr = 4'($urandom);
                load_data = $urandom;
            end else begin
                load_en = 1'b0;
            end
            if (bus.in_valid) pulses++;
            if (k == exp_issue) begin
                check("issue_vld", 64'(bus.in_valid), 64'd1);
                check("issue_inst", 64'(bus.inst), 64'(ref_mem[pc]));
                check("issue_cnt", 64'(issued_cnt), 64'(sat(issues)));
                check("issue_flags", 64'({done, error}), 64'd0);
                issues++;
                resp_cyc = k + (rnd ? int'($urandom_range(1, 6)) : 1);
            end
            if (k == resp_cyc) begin
                if (!rnd) begin
                    a = (plan.size() > 0) ? plan.pop_front() : 32'(len * 4);
                end else begin
                    r = int'($urandom_range(0, 19));
                    if (issues >= 40)  a = 32'(len * 4);
                    else if (r == 0)   a = 32'(pc * 4 + int'($urandom_range(1, 3)));
                    else if (r <= 3)   a = 32'(int'($urandom_range(0, len + 1)) * 4);
                    else               a = 32'((pc + 1) * 4);
                end
                bus.out_valid = 1'b1;
                bus.inst_addr = a;
                if ((a % 4) != 0 || a >= 64) begin
                    fin = 1'b1; kind = 2;
                end else if (int'(a / 4) >= len) begin
                    fin = 1'b1; kind = 1;
                end else begin
                    pc = int'(a / 4);
                    exp_issue = k + 2;
                end
            end
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL run_bound cycles=%0d required=terminate", k);
        end
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
            load_en = 1'b0;
            bus.out_valid = 1'b0;
            if (bus.in_valid) pulses++;
        end
        check("pulses", 64'(pulses), 64'(issues));
        check("end_done", 64'(done), 64'(kind == 1));
        check("end_error", 64'(error), 64'(kind == 2));
        check("end_code", 64'(err_code), (kind == 2) ? 64'd1 : 64'd0);
        check("end_cnt", 64'(issued_cnt), 64'(sat(issues)));
    endtask

    initial begin
        int np;
        rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; prog_len = '0;
        bus.out_valid = 1'b0; bus.inst_addr = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        rst = 1'b0;
        @(negedge clk);

        // Single-response decode table against pattern C0DE_00ii.
        vecs[0]  = '{32'h04,       8,  1'b1, 32'hC0DE0001, 1'b0, 1'b0, 2'd0};
        vecs[1]  = '{32'h18,       8,  1'b1, 32'hC0DE0006, 1'b0, 1'b0, 2'd0};
        vecs[2]  = '{32'h00,       8,  1'b1, 32'hC0DE0000, 1'b0, 1'b0, 2'd0};
        vecs[3]  = '{32'h1C,       8,  1'b1, 32'hC0DE0007, 1'b0, 1'b0, 2'd0};
        vecs[4]  = '{32'h20,       8,  1'b0, 32'h0,        1'b1, 1'b0, 2'd0};
        vecs[5]  = '{32'h3C,       16, 1'b1, 32'hC0DE000F, 1'b0, 1'b0, 2'd0};
        vecs[6]  = '{32'h3C,       15, 1'b0, 32'h0,        1'b1, 1'b0, 2'd0};
        vecs[7]  = '{32'h06,       8,  1'b0, 32'h0,        1'b0, 1'b1, 2'd1};
        vecs[8]  = '{32'h05,       8,  1'b0, 32'h0,        1'b0, 1'b1, 2'd1};
        vecs[9]  = '{32'h40,       16, 1'b0, 32'h0,        1'b0, 1'b1, 2'd1};
        vecs[10] = '{32'h80000000, 16, 1'b0, 32'h0,        1'b0, 1'b1, 2'd1};
        vecs[11] = '{32'h04,       1,  1'b0, 32'h0,        1'b1, 1'b0, 2'd0};
        for (int i = 0; i < 16; i++) load_word(i, 32'hC0DE0000 + 32'(i));
        for (int v = 0; v < 12; v++) begin
            start = 1'b1; prog_len = 5'(vecs[v].len);
            @(negedge clk); start = 1'b0;
            @(negedge clk);
            check("tbl_first", 64'({bus.in_valid, bus.inst}), 64'({1'b1, 32'hC0DE0000}));
            @(negedge clk);
            bus.out_valid = 1'b1; bus.inst_addr = vecs[v].addr;
            @(negedge clk);
            bus.out_valid = 1'b0;
            @(negedge clk);
            check("tbl_vld", 64'(bus.in_valid), 64'(vecs[v].vld));
            if (vecs[v].vld) check("tbl_inst", 64'(bus.inst), 64'(vecs[v].inst));
            check("tbl_status", 64'({done, error, err_code}),
                  64'({vecs[v].dn, vecs[v].er, vecs[v].code}));
            do_reset();
        end

        // Straight-line program.
        for (int i = 0; i < 4; i++) load_word(i, 32'h20010001 + 32'(i));
        plan = '{32'h4, 32'h8, 32'hC, 32'h10};
        run_core(4, 1'b0);

        // Branch from word 1 to word 6, then off the end.
        plan = '{32'h4, 32'h18, 32'h20};
        run_core(8, 1'b0);

        // Misaligned response, then a restart reissues word 0.
        plan = '{32'h06};
        run_core(4, 1'b0);
        plan = '{32'h4, 32'h8, 32'hC, 32'h10};
        run_core(4, 1'b0);

        // Load of word 0 in the start cycle is seen by the first fetch.
        load_en = 1'b1; load_addr = 4'd0; load_data = 32'h5A5A0000;
        ref_mem[0] = 32'h5A5A0000;
        plan = '{32'h10};
        run_core(4, 1'b0);

        // Timeout: no response through the 16th wait cycle.
        start = 1'b1; prog_len = 5'd4;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        check("to_issue", 64'(bus.in_valid), 64'd1);
        repeat (16) @(negedge clk);
        check("to_before", 64'(error), 64'd0);
        @(negedge clk);
        check("to_flag", 64'({error, err_code}), 64'({1'b1, 2'd2}));
        check("to_no_issue", 64'(bus.in_valid), 64'd0);

        // Response on the 16th wait cycle is still accepted.
        start = 1'b1; prog_len = 5'd4;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        repeat (16) @(negedge clk);
        bus.out_valid = 1'b1; bus.inst_addr = 32'h10;
        @(negedge clk);
        bus.out_valid = 1'b0;
        check("to_edge_ok", 64'({done, error, err_code}), 64'({1'b1, 1'b0, 2'd0}));

        // Same-cycle response to in_valid, then out_valid while in ERR.
        start = 1'b1; prog_len = 5'd4;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        check("sp_issue", 64'(bus.in_valid), 64'd1);
        bus.out_valid = 1'b1; bus.inst_addr = 32'h4;
        @(negedge clk);
        check("sp_flag", 64'({error, err_code}), 64'({1'b1, 2'd3}));
        bus.inst_addr = 32'h6;
        np = 0;
        repeat (4) begin
            @(negedge clk);
            bus.out_valid = 1'b0;
            if (bus.in_valid) np++;
        end
        check("sp_sticky", 64'({error, err_code}), 64'({1'b1, 2'd3}));
        check("sp_no_issue", 64'(np), 64'd0);
        do_reset();

        // Stray out_valid in IDLE; a later start still runs.
        bus.out_valid = 1'b1; bus.inst_addr = 32'h0;
        @(negedge clk);
        bus.out_valid = 1'b0;
        check("sp_idle", 64'({error, err_code}), 64'({1'b1, 2'd3}));
        plan = '{32'h10};
        run_core(4, 1'b0);

        // Reset during WAIT, then identical rerun.
        start = 1'b1; prog_len = 5'd4;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_wait");
        rst = 1'b0;
        np = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.in_valid) np++;
        end
        check("rst_quiet", 64'(np), 64'd0);
        plan = '{32'h4, 32'h8, 32'hC, 32'h10};
        run_core(4, 1'b0);

        // Counter saturation: loop on word 0 for 21 issues.
        plan = {};
        for (int i = 0; i < 20; i++) plan.push_back(32'h0);
        plan.push_back(32'h8);
        run_core(2, 1'b0);

        // Randomized programs, responses and ignored mid-run loads.
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 16; i++) load_word(i, $urandom);
            run_core(int'($urandom_range(0, 15)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
